// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the counter sequencer.
// State encoding plus default width and prescale values.
package counter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_PRESCALE = 4;

    localparam int WRAP_W = 8;

    // Saturating increment for the reload counter.
    function automatic logic [WRAP_W-1:0] sat_inc(
        input logic [WRAP_W-1:0] v
    );
        return (v == {WRAP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/counter_tick_gen.sv
// counter_tick_gen: prescaler giving a one-cycle tick every PRESCALE
// enabled clocks; clr restarts the period. Used with COUNTER_SEQUENCER_PRESCALE_EN.
module counter_tick_gen
    import counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = en & w_last;

    // Period counter: frozen when disabled, restarted by clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: launches, counts and stops/reloads an up/down counter.
// Optional prescaled stepping via macro COUNTER_SEQUENCER_PRESCALE_EN.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    input  logic [WIDTH-1:0]  cfg_limit,
    input  logic              cfg_down,
    input  logic              cfg_reload,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_sequencer: PRESCALE must be >= 1");
    end

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_limit;
    logic               r_down;
    logic               r_reload;

    logic [WIDTH-1:0]   r_q;
    logic               r_busy;
    logic               r_done;
    logic [WRAP_W-1:0]  r_wrap;

    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_done_nxt;
    logic [WRAP_W-1:0]  w_wrap_nxt;

    logic               w_tick;
    logic               w_launch;
    logic               w_step;
    logic               w_at_term;
    logic [WIDTH-1:0]   w_term;
    logic [WIDTH-1:0]   w_launch_val;
    logic [WIDTH-1:0]   w_reload_val;

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
    logic w_tg_en;
    logic w_tg_clr;

    assign w_tg_en  = (r_state == S_RUN) & ~hold;
    assign w_tg_clr = w_launch | stop;

    counter_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (w_tg_clr),
        .en    (w_tg_en),
        .tick  (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    assign w_launch = start & ~stop &
                      ((r_state == S_IDLE) | (r_state == S_DONE));

    // hold freezes both the count and the terminal check.
    assign w_step = (r_state == S_RUN) & ~stop & ~hold & w_tick;

    assign w_term       = r_down ? '0 : r_limit;
    assign w_at_term    = (r_q == w_term);
    assign w_launch_val = cfg_down ? cfg_limit : '0;
    assign w_reload_val = r_down ? r_limit : '0;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: stop beats start, start only from IDLE/DONE.
    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_step && w_at_term && !r_reload) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output/datapath next values; terminal action fires one step after q hits terminal.
    always_comb begin
        w_q_nxt    = r_q;
        w_done_nxt = 1'b0;
        w_wrap_nxt = r_wrap;
        if (stop) begin
            w_q_nxt    = '0;
            w_wrap_nxt = '0;
        end else if (w_launch) begin
            w_q_nxt    = w_launch_val;
            w_wrap_nxt = '0;
        end else if (w_step) begin
            if (!w_at_term) begin
                w_q_nxt = r_down ? r_q - 1'b1 : r_q + 1'b1;
            end else if (r_reload) begin
                w_q_nxt    = w_reload_val;
                w_wrap_nxt = sat_inc(r_wrap);
                w_done_nxt = 1'b1;
            end else begin
                w_done_nxt = 1'b1;
            end
        end
    end

    // Configuration is captured only at launch so a run is unaffected by cfg_* changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_limit  <= '0;
            r_down   <= 1'b0;
            r_reload <= 1'b0;
        end else if (w_launch) begin
            r_limit  <= cfg_limit;
            r_down   <= cfg_down;
            r_reload <= cfg_reload;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_wrap <= '0;
        end else begin
            r_q    <= w_q_nxt;
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= w_done_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign q        = r_q;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wrap_cnt = r_wrap;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: scoreboard bench with a step-index reference model.
// Directed scenarios followed by randomized control traffic.
module tb_counter_sequencer;

    localparam int P = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       hold;
    logic [7:0] cfg_limit;
    logic       cfg_down;
    logic       cfg_reload;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic [7:0] wrap_cnt;

    counter_sequencer #(
        .WIDTH    (8),
        .PRESCALE (P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .cfg_limit  (cfg_limit),
        .cfg_down   (cfg_down),
        .cfg_reload (cfg_reload),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .wrap_cnt   (wrap_cnt)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic [7:0] wrap;
    } obs_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: a run is described by its step index n since launch.
    // mode 0 = idle, 1 = running, 2 = finished one-shot.
    int m_mode;
    int m_n;
    int m_e;
    int m_lim;
    bit m_dn;
    bit m_rl;
    bit m_done;

    function automatic void model_reset();
        m_mode = 0;
        m_n    = 0;
        m_e    = 0;
        m_lim  = 0;
        m_dn   = 0;
        m_rl   = 0;
        m_done = 0;
    endfunction

    function automatic void model_edge();
        bit tick;
        m_done = 0;
        if (stop) begin
            m_mode = 0;
        end else if (m_mode != 1 && start) begin
            m_lim  = int'(cfg_limit);
            m_dn   = cfg_down;
            m_rl   = cfg_reload;
            m_n    = 0;
            m_e    = 0;
            m_mode = 1;
        end else if (m_mode == 1 && !hold) begin
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
            m_e++;
            tick = (m_e % P == 0);
`else
            tick = 1;
`endif
            if (tick) begin
                m_n++;
                if (m_rl) begin
                    if (m_n % (m_lim + 1) == 0) m_done = 1;
                end else if (m_n == m_lim + 1) begin
                    m_done = 1;
                    m_mode = 2;
                end
            end
        end
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        int   k;
        int   w;
        o      = '0;
        o.done = m_done;
        o.busy = (m_mode == 1);
        if (m_mode == 1) begin
            k   = m_n % (m_lim + 1);
            o.q = m_dn ? 8'(m_lim - k) : 8'(k);
            if (m_rl) begin
                w      = m_n / (m_lim + 1);
                o.wrap = (w > 255) ? 8'd255 : 8'(w);
            end
        end else if (m_mode == 2) begin
            o.q = m_dn ? 8'd0 : 8'(m_lim);
        end
        return o;
    endfunction

    // Drive one cycle of inputs away from the edge, then predict the edge result.
    task automatic cyc(input bit st, input bit sp, input bit hd,
                       input int lim, input bit dn, input bit rl);
        @(negedge clk);
        start      = st;
        stop       = sp;
        hold       = hd;
        cfg_limit  = 8'(lim);
        cfg_down   = dn;
        cfg_reload = rl;
        @(posedge clk);
        model_edge();
        sb.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_now(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: every registered output update is checked against the queue.
    initial begin
        obs_t got;
        obs_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp  = sb.pop_front();
                got  = '{q: q, busy: busy, done: done, wrap: wrap_cnt};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL obs @%0t: got q=%0d busy=%0b done=%0b wrap=%0d, expected q=%0d busy=%0b done=%0b wrap=%0d",
                             $time, got.q, got.busy, got.done, got.wrap,
                             exp.q, exp.busy, exp.done, exp.wrap);
                end
            end
        end
    end

    initial begin
        start      = 0;
        stop       = 0;
        hold       = 0;
        cfg_limit  = 0;
        cfg_down   = 0;
        cfg_reload = 0;
        reset      = 0;
        model_reset();
        #60;
        chk_now("por_q", int'(q), 0);
        chk_now("por_busy", int'(busy), 0);
        reset = 1;

        idle(3);

        // One-shot up to 5.
        cyc(1, 0, 0, 5, 0, 0);
        idle(9);

        // Auto-reload down from 3, then stop.
        cyc(1, 0, 0, 3, 1, 1);
        idle(10);
        cyc(0, 1, 0, 0, 0, 0);

        // Hold at q=4 for three cycles, then stop with start.
        cyc(1, 0, 0, 10, 0, 0);
        idle(4);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 1, 0, 7, 1, 1);
        idle(2);

        // Limit 0 one-shot and auto-reload.
        cyc(1, 0, 0, 0, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0, 1, 1);
        idle(4);
        cyc(0, 1, 0, 0, 0, 0);

        // Full-range up count.
        cyc(1, 0, 0, 255, 0, 0);
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
        idle(256 * P + 8);
`else
        idle(260);
`endif

        // Asynchronous reset in the middle of a run.
        cyc(1, 0, 0, 20, 0, 0);
        idle(6 * P);
        @(negedge clk);
        #10;
        reset = 0;
        #1;
        chk_now("arst_q", int'(q), 0);
        chk_now("arst_busy", int'(busy), 0);
        chk_now("arst_done", int'(done), 0);
        chk_now("arst_wrap", int'(wrap_cnt), 0);
        #99;
        model_reset();
        reset = 1;
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit st;
            bit sp;
            bit hd;
            int lim;
            st  = ($urandom_range(0, 9) == 0);
            sp  = ($urandom_range(0, 59) == 0);
            hd  = ($urandom_range(0, 6) == 0);
            lim = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 9));
            cyc(st, sp, hd, lim, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #2;
        chk_now("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that owns and sequences an 8-bit synchronous counter: launches a count run, counts up or down to a programmed limit, then stops (one-shot) or reloads (auto-reload).
- Sits between control logic (buttons/FSMs on the FPGA lab board) and anything consuming the count value (LEDs, 7-seg decoder).
- Control inputs are latched at launch, so the downstream count is stable and glitch-free.

Parameters:
- WIDTH, 8, counter and limit width in bits.
- PRESCALE, 4, clock cycles per count step; used only when PRESCALE_EN is defined; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- start  input  1  level; launches a run when sampled 1 in IDLE or DONE.
- stop  input  1  level; aborts any state to IDLE and clears q.
- hold  input  1  level; freezes q while in RUN.
- cfg_limit  input  WIDTH  terminal value for up-count, start value for down-count.
- cfg_down  input  1  0 = count 0 to limit; 1 = count limit to 0.
- cfg_reload  input  1  0 = one-shot; 1 = auto-reload.
- q  output  WIDTH  current count.
- busy  output  1  1 while in RUN.
- done  output  1  one-cycle pulse at each terminal event.
- wrap_cnt  output  8  number of reloads since launch; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - q=0, busy=0, done=0, wrap_cnt=0.
  - Latched config cleared (limit=0, down=0, reload=0).
- States are IDLE, RUN and DONE. busy = (state==RUN). All outputs are registered.
- Priority on any edge: stop > start > hold > count.
- IDLE or DONE with start=1:
  - Latch cfg_limit, cfg_down and cfg_reload.
  - Load q with the start value: 0 if up, limit if down.
  - Clear wrap_cnt and go to RUN.
  - Latency: busy=1 and q=start value one edge after start is sampled.
- RUN: the terminal value is limit when counting up and 0 when counting down. On each edge (or each tick with PRESCALE_EN):
  - If hold=1: q, wrap_cnt and the terminal check are all frozen.
  - Else if q != terminal: q <= q+1 (up) or q-1 (down).
  - Else if q == terminal and reload=1: q <= start value, wrap_cnt <= min(wrap_cnt+1, 255), done=1 for one cycle; stay in RUN.
  - Else if q == terminal and reload=0: q holds terminal, done=1 for one cycle, go to DONE.
- Terminal latency: q reaches terminal on edge k; the terminal action (done pulse, reload or DONE) happens on edge k+1. q therefore dwells at terminal for exactly one step.
- limit=0: start value equals terminal, so done pulses one step after launch.
  - Auto-reload with limit=0 gives done every step and q stuck at 0.
- start while in RUN is ignored. cfg_* changes during RUN are ignored until the next launch.
- DONE: q holds terminal, busy=0. start relaunches directly from DONE; stop returns to IDLE with q=0.
- stop in any state: next edge gives IDLE, q=0, wrap_cnt=0, no done pulse. stop and start together resolve to stop.
- Arithmetic stays within 0..limit, so no modular wrap occurs beyond WIDTH.
- Reset asserted mid-run aborts immediately to the reset values above. After release, the block waits in IDLE for start.

Optional Feature:
- Macro COUNTER_SEQUENCER_PRESCALE_EN.
- Defined:
  - An internal prescaler produces a one-cycle tick every PRESCALE clocks.
  - Count steps and terminal actions happen only on tick edges; hold also freezes the prescaler.
  - The prescaler is cleared on launch, stop and reset. The first step occurs PRESCALE clocks after launch.
- Undefined: tick is tied to 1, every clock is a step, and no prescaler logic is present.

Decomposition:
- Shared package counter_pkg:
  - State encoding constants: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default WIDTH and PRESCALE constants.
- One sub-module, counter_tick_gen: prescaler producing tick, with ports clk, reset, clr, en, tick. It is instantiated only under the macro.
- The FSM and the count register stay in counter_sequencer.

Test Plan (clock period 50 ns):
- Reset: hold reset=0 for 100 ns mid-run → q=0, busy=0, done=0 immediately, without waiting for a clock edge. Release reset with start=0 → stays in IDLE.
- One-shot up: limit=5, down=0, reload=0, pulse start → q goes 0,1,2,3,4,5 on successive edges. done is high for one cycle on the edge after q=5. busy falls to 0, state is DONE, q holds 5.
- Auto-reload down: limit=3, down=1, reload=1 → q repeats 3,2,1,0,3,... with one done per cycle through. wrap_cnt=2 after two reloads.
- Hold and stop: during a limit=10 up run, hold=1 for 3 cycles at q=4 → q stays 4, no done. Then stop=1 together with start=1 → IDLE, q=0, wrap_cnt=0, no done.
- Boundary limit=0: one-shot → done one cycle after launch, q=0. limit=255 up → q reaches 255 with no wrap to 0, then done.
- With COUNTER_SEQUENCER_PRESCALE_EN and PRESCALE=4: limit=2 up → q changes only every 4th edge, and done arrives 12 clocks after launch.
